// File: rtl/simon_pkg.sv
// Shared constants for the Simon 64/128 round controller: round count,
// ctrl encodings and the FSM state encoding seen on dbg_state.
package simon_pkg;

    localparam int ROUNDS = 44;

    localparam logic CTRL_ENC = 1'b0;
    localparam logic CTRL_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        KEY_EXP = 3'd2,
        ENC_RUN = 3'd3,
        DEC_RUN = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/simon_round_cnt.sv
// Loadable up/down round counter with a direction-aware terminal-count flag.
// Saturates at 0 and MAX_VAL so key_addr can never wrap.
module simon_round_cnt #(
    parameter int RND_W   = 6,
    parameter int MAX_VAL = 43
) (
    input  logic             clk,
    input  logic             res,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [RND_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_down,
    output logic [RND_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [RND_W-1:0] LP_MAX = RND_W'(MAX_VAL);
    localparam logic [RND_W-1:0] LP_ONE = RND_W'(1);

    logic [RND_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (i_down) begin
                if (r_cnt != '0) r_cnt <= r_cnt - LP_ONE;
            end else begin
                if (r_cnt != LP_MAX) r_cnt <= r_cnt + LP_ONE;
            end
        end
    end

    assign o_tc  = i_down ? (r_cnt == '0) : (r_cnt == LP_MAX);
    assign o_cnt = r_cnt;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round controller: sequences load, key expansion and encrypt/decrypt
// rounds, and reuses the expanded round keys for decrypt when still valid.
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS = simon_pkg::ROUNDS,
    parameter int RND_W  = 6
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             ctrl,
    input  logic             new_key,
    input  logic             out_ack,
    output logic             busy,
    output logic             load,
    output logic             round_en,
    output logic             key_wr_en,
    output logic [RND_W-1:0] key_addr,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam logic [RND_W-1:0] LP_LAST = RND_W'(ROUNDS - 1);

    state_e           r_state;
    state_e           w_next;
    logic             r_ctrl;
    logic             r_new_key;
    logic             r_keys_valid;
    logic             w_kv_clr;
    logic             w_kv_set;
    logic             w_cnt_clr;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_cnt_down;
    logic             w_cnt_tc;
    logic [RND_W-1:0] w_cnt;

    simon_round_cnt #(
        .RND_W  (RND_W),
        .MAX_VAL(ROUNDS - 1)
    ) u_cnt (
        .clk       (clk),
        .res       (res),
        .i_clr     (w_cnt_clr),
        .i_load    (w_cnt_load),
        .i_load_val(LP_LAST),
        .i_en      (w_cnt_en),
        .i_down    (w_cnt_down),
        .o_cnt     (w_cnt),
        .o_tc      (w_cnt_tc)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= IDLE;
            r_ctrl       <= CTRL_ENC;
            r_new_key    <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_ctrl    <= ctrl;
                r_new_key <= new_key;
            end
            if (w_kv_clr)      r_keys_valid <= 1'b0;
            else if (w_kv_set) r_keys_valid <= 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        w_kv_clr   = 1'b0;
        w_kv_set   = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        w_cnt_down = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                if (r_ctrl == CTRL_ENC) begin
                    w_next    = ENC_RUN;
                    w_kv_clr  = 1'b1;
                    w_cnt_clr = 1'b1;
                end else if (r_keys_valid && !r_new_key) begin
                    w_next     = DEC_RUN;
                    w_cnt_load = 1'b1;
                end else begin
                    w_next    = KEY_EXP;
                    w_kv_clr  = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            KEY_EXP: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_next     = DEC_RUN;
                    w_kv_set   = 1'b1;
                    w_cnt_load = 1'b1;
                end
            end
            ENC_RUN: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_next    = DONE;
                    w_kv_set  = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            DEC_RUN: begin
                w_cnt_en   = 1'b1;
                w_cnt_down = 1'b1;
                if (w_cnt_tc) begin
                    w_next    = DONE;
                    w_cnt_clr = 1'b1;
                end
            end
            DONE: begin
                if (out_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs decode registered state only; the counter sits at 0 outside runs.
    assign busy      = (r_state != IDLE);
    assign load      = (r_state == LOAD);
    assign round_en  = (r_state == ENC_RUN) || (r_state == DEC_RUN);
    assign key_wr_en = (r_state == ENC_RUN) || (r_state == KEY_EXP);
    assign done      = (r_state == DONE);
    assign key_addr  = w_cnt;
    assign dbg_state = r_state;

endmodule
